// File: rtl/fir_out_requant.sv
// Requantises the 32-bit FIR result stream to 16-bit signed (round, shift, saturate)
// and buffers it in a small FIFO behind a valid/ready source, with drop/saturation statistics.
module fir_out_requant #(
    parameter int SHIFT = 15,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              ast_sink_data,
    input  logic                     ast_sink_valid,
    output logic [15:0]              ast_source_data,
    output logic                     ast_source_valid,
    input  logic                     ast_source_ready,
    input  logic                     clear,
    output logic                     overflow,
    output logic [15:0]              sat_count,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam int RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic signed [32:0] RND = (SHIFT > 0) ? (33'sd1 <<< RND_SH) : 33'sd0;

    // Returns {sat, value}; the 33-bit sum cannot overflow since RND <= 2^15.
    function automatic logic [16:0] requant(input logic [31:0] x);
        logic signed [32:0] ext;
        logic signed [32:0] sum;
        logic signed [32:0] r;
        logic [16:0]        res;
        ext = $signed({x[31], x});
        sum = ext + RND;
        r   = sum >>> SHIFT;
        if (r > 33'sd32767) begin
            res = {1'b1, 16'h7FFF};
        end else if (r < -33'sd32768) begin
            res = {1'b1, 16'h8000};
        end else begin
            res = {1'b0, r[15:0]};
        end
        return res;
    endfunction

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_fill;
    logic          r_overflow;
    logic [15:0]   r_sat_count;
    logic [15:0]   r_drop_count;

    logic [16:0]   w_req;
    logic          w_sat;
    logic          w_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [AW:0]   w_fill_nxt;

    assign w_req   = requant(ast_sink_data);
    assign w_sat   = w_req[16];
    assign w_valid = (r_fill != '0);
    assign w_full  = (r_fill == FULL_LVL);
    assign w_pop   = w_valid & ast_source_ready;
    assign w_wr    = ast_sink_valid & (~w_full | w_pop);
    assign w_drop  = ast_sink_valid & w_full & ~w_pop;

    // Occupancy next-state: only write-only or pop-only moves the level.
    always_comb begin
        w_fill_nxt = r_fill;
        case ({w_wr, w_pop})
            2'b10:   w_fill_nxt = r_fill + 1'b1;
            2'b01:   w_fill_nxt = r_fill - 1'b1;
            default: w_fill_nxt = r_fill;
        endcase
    end

    // Sample storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_req[15:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_fill <= w_fill_nxt;
        end
    end

    // Statistics; clear takes priority over any same-cycle event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_sat_count  <= 16'd0;
            r_drop_count <= 16'd0;
        end else if (clear) begin
            r_overflow   <= 1'b0;
            r_sat_count  <= 16'd0;
            r_drop_count <= 16'd0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_wr && w_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign ast_source_valid = w_valid;
    assign ast_source_data  = w_valid ? r_mem[r_rd_ptr] : 16'd0;
    assign fill_level       = r_fill;
    assign overflow         = r_overflow;
    assign sat_count        = r_sat_count;
    assign drop_count       = r_drop_count;

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Downstream stage of the FIR core. Consumes the 32-bit signed FIR result stream (valid-only, no backpressure) and rounds, shifts and saturates each sample to 16-bit signed.
- Buffers results in a small FIFO so a backpressuring consumer (DAC or sample sink) can be attached through a valid/ready Avalon-ST source.
- Reports saturation and dropped-sample statistics.

Parameters:
- SHIFT, 15, right-shift applied to the FIR output. Legal range 0..16. Matches Q15 coefficients.
- DEPTH, 8, FIFO depth in entries. Power of two, minimum 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- ast_sink_data  in  32  signed FIR output sample.
- ast_sink_valid  in  1  sample present this cycle. There is no ready output; the upstream stage cannot stall.
- ast_source_data  out  16  signed requantised sample at the FIFO head.
- ast_source_valid  out  1  FIFO non-empty.
- ast_source_ready  in  1  consumer accepts the head sample this cycle.
- clear  in  1  synchronous clear of statistics. Does not touch FIFO contents.
- overflow  out  1  sticky; set when a sample was dropped.
- sat_count  out  16  number of accepted samples that saturated. Saturates at 0xFFFF.
- drop_count  out  16  number of samples dropped because the FIFO was full. Saturates at 0xFFFF.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rd_ptr, wr_ptr and fill_level go to 0.
  - ast_source_valid = 0.
  - overflow = 0; sat_count = drop_count = 0.
  - ast_source_data = 0 while empty; ast_source_data is driven to 0 whenever the FIFO is empty.
  - FIFO memory is not reset.
  - Reset mid-stream discards all buffered samples. No partial state survives.
- Arithmetic (combinational, on ast_sink_data = x):
  - Sign-extend x to 33 bits.
  - If SHIFT > 0, add 2^(SHIFT-1). This is round-half-up, toward +inf.
  - Arithmetic right shift by SHIFT, giving r.
  - If r > 32767, output 32767; if r < -32768, output -32768. Either case flags sat = 1.
  - SHIFT = 0: no rounding add; pure saturation of x.
- Write rule:
  - When ast_sink_valid = 1: write if (fill_level < DEPTH) or (pop in the same cycle).
  - A write stores the requantised value at wr_ptr and increments wr_ptr, wrapping modulo DEPTH.
  - A write with sat = 1 increments sat_count.
- Drop rule:
  - When ast_sink_valid = 1, fill_level = DEPTH and no pop, the sample is discarded.
  - overflow is set to 1 and drop_count increments. FIFO state is unchanged.
- Pop rule:
  - pop = ast_source_valid & ast_source_ready.
  - On a pop, rd_ptr increments, wrapping modulo DEPTH.
  - ast_source_ready while empty has no effect.
- Occupancy: fill_level +1 on write-only, -1 on pop-only, unchanged on simultaneous write+pop or on neither.
- Outputs:
  - ast_source_valid = (fill_level != 0), registered-derived.
  - ast_source_data = mem[rd_ptr].
  - Latency: a sample accepted at edge N is visible on the source after edge N (one cycle) when the FIFO was empty.
- Handshake:
  - ast_source_data and ast_source_valid hold stable while valid=1 and ready=0.
  - Ordering is strictly FIFO.
- clear:
  - Synchronous. Next edge sets overflow = 0, sat_count = 0, drop_count = 0.
  - If clear coincides with a drop or a saturating write, clear wins; counters read 0.
- Counters stick at 0xFFFF; they do not wrap.

Test Plan:
- SHIFT=15, single samples, ready=1. Required outputs, each one cycle after input:
  - 16384 -> 1
  - 16383 -> 0
  - -16384 -> 0
  - -16385 -> -1
  - 268435456 -> 8192
  - sat_count stays 0.
- Saturation: input 0x7FFFFFFF -> 32767; input 0x80000000 -> -32768; sat_count = 2 afterwards; overflow stays 0.
- Backpressure/overflow with DEPTH=8:
  - Hold ready=0 and stream 10 valid samples 1..10 (pre-shift values k*32768).
  - fill_level reaches 8; samples 9 and 10 are dropped; drop_count = 2; overflow = 1.
  - Then ready=1: outputs 1..8 in order, then valid = 0.
- Full with simultaneous write+pop: FIFO full, ready=1 and valid input together. Required: sample written, fill_level stays 8, no drop, drop_count unchanged.
- clear: after the overflow test, pulse clear for one cycle. Required: overflow, sat_count and drop_count read 0 next cycle; fill_level unchanged.
- Reset mid-stream: assert reset_n=0 asynchronously between edges with 5 entries buffered. Required: ast_source_valid = 0 and fill_level = 0 immediately; after release, the first new sample appears with 1-cycle latency.
